// File: rtl/fetch.sv
// Instruction fetch stage with a generic shift-register FIFO; FETCH_ALIGN_CHECK_EN adds misaligned-redirect halt.
// Latency: request accepted in cycle t, response in cycle t+k -> instruction_valid in cycle t+k+1.
// Backpressure: requests gated by credits (outstanding + buffered < FIFO_DEPTH); decode_ready holds the head.

module fifo #(
    parameter int               WIDTH     = 64,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop_vld,
    output logic [WIDTH-1:0]           head_dat,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem     [DEPTH];
    logic [WIDTH-1:0] mem_nxt [DEPTH];
    logic             do_push;
    logic             do_pop;
    logic [LW-1:0]    wr_idx;

    assign do_pop   = pop_vld && (level != '0);
    assign do_push  = push_vld && (do_pop || (level != LW'(DEPTH)));
    assign head_dat = mem[0];

    // Entry 0 is always the head, so the output comes straight from a flop.
    always_comb begin
        mem_nxt = mem;
        wr_idx  = do_pop ? level - LW'(1) : level;
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_nxt[i] = mem[i+1];
            end
        end
        if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (LW'(i) == wr_idx) begin
                    mem_nxt[i] = push_dat;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (flush) begin
            level <= '0;
        end else begin
            level <= level + LW'(do_push) - LW'(do_pop);
            mem   <= mem_nxt;
        end
    end
endmodule

module fetch #(
    parameter int                   WORD_SIZE  = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
    parameter int                   FIFO_DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [WORD_SIZE-1:0] imem_req_addr,
    input  logic                 imem_resp_valid,
    input  logic [WORD_SIZE-1:0] imem_resp_data,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic [WORD_SIZE-1:0] instruction,
    output logic [WORD_SIZE-1:0] instruction_pc,
    output logic                 instruction_valid,
    input  logic                 decode_ready,
    output logic                 fetch_misaligned
);
    localparam int                   CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [WORD_SIZE-1:0] NOP = WORD_SIZE'(32'h0000_0013);

    typedef struct packed {
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] insn;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH
`ifdef FETCH_ALIGN_CHECK_EN
        , HALT
`endif
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] resp_pc;
    logic [WORD_SIZE-1:0] redirect_aligned;
    logic [CW-1:0]        outstanding;
    logic [CW-1:0]        drop;
    logic [CW-1:0]        count;
    logic [CW:0]          credit_used;
    logic                 req_vld;
    logic                 req_fire;
    logic                 resp_ok;
    logic                 push_vld;
    logic                 pop_vld;
    entry_t               push_dat;
    entry_t               head_dat;

    assign redirect_aligned = redirect_pc & ~WORD_SIZE'(3);
    assign credit_used      = {1'b0, outstanding} + {1'b0, count};
    assign req_fire         = req_vld && imem_req_ready;
    // A response with nothing outstanding belongs to a request from before reset.
    assign resp_ok          = imem_resp_valid && (outstanding != '0);
    assign push_vld         = resp_ok && (drop == '0) && !redirect_valid;
    assign pop_vld          = instruction_valid && decode_ready;
    assign push_dat         = '{pc: resp_pc, insn: imem_resp_data};

    assign imem_req_valid    = req_vld;
    assign imem_req_addr     = pc;
    assign instruction_valid = (count != '0);
    assign instruction       = instruction_valid ? head_dat.insn : NOP;
    assign instruction_pc    = head_dat.pc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned_redirect;
    logic misaligned_q;

    assign misaligned_redirect = |redirect_pc[1:0];
    assign fetch_misaligned    = misaligned_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            misaligned_q <= 1'b0;
        end else if (redirect_valid) begin
            misaligned_q <= misaligned_redirect;
        end
    end
`else
    assign fetch_misaligned = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_vld   = 1'b0;
        if (state == IDLE) begin
            state_nxt = FETCH;
        end
        if (state == FETCH && !redirect_valid && credit_used < (CW+1)'(FIFO_DEPTH)) begin
            req_vld = 1'b1;
        end
        if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
            state_nxt = misaligned_redirect ? HALT : FETCH;
`else
            state_nxt = FETCH;
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_ok);
            if (redirect_valid) begin
                // Everything still in flight belongs to the old stream.
                pc      <= redirect_aligned;
                resp_pc <= redirect_aligned;
                drop    <= outstanding - CW'(resp_ok);
            end else begin
                if (req_fire) begin
                    pc <= pc + WORD_SIZE'(4);
                end
                if (push_vld) begin
                    resp_pc <= resp_pc + WORD_SIZE'(4);
                end
                if (resp_ok && drop != '0) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    fifo #(
        .WIDTH     ($bits(entry_t)),
        .DEPTH     (FIFO_DEPTH),
        .RESET_VAL ({RESET_PC, NOP})
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (redirect_valid),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop_vld  (pop_vld),
        .head_dat (head_dat),
        .level    (count)
    );
endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: in-order memory model with configurable latency, scoreboard of {pc, word}.
module tb_fetch;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instruction;
    logic [31:0] instruction_pc;
    logic        instruction_valid;
    logic        decode_ready;
    logic        fetch_misaligned;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc;
    int          cyc = 0;
    int          lat = 1;
    int          first_acc = -1;
    int          first_val = -1;
    int          n_deliv = 0;
    int          n_total = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          reqs;
    bit          found;

    always #5 clock = ~clock;

    fetch dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .instruction       (instruction),
        .instruction_pc    (instruction_pc),
        .instruction_valid (instruction_valid),
        .decode_ready      (decode_ready),
        .fetch_misaligned  (fetch_misaligned)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory: in-order responses, each no earlier than lat cycles after acceptance.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            if (!reset_n) begin
                mem_q.delete();
                imem_resp_valid = 1'b0;
            end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = word(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
        end
    end

    // Scoreboard: accepts push {pc, word}; redirects invalidate everything pending.
    initial begin
        mreq_t m;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                exp_q.delete();
                mem_q.delete();
                exp_pc = 32'h0;
            end else begin
                if (imem_req_valid && imem_req_ready) begin
                    chk("req_addr", 64'(imem_req_addr), 64'(exp_pc));
                    m.due  = cyc + lat;
                    m.addr = imem_req_addr;
                    mem_q.push_back(m);
                    exp_q.push_back({imem_req_addr, word(imem_req_addr)});
                    exp_pc += 32'd4;
                    if (first_acc < 0) first_acc = cyc;
                end
                if (redirect_valid) begin
                    chk("no_req_on_redirect", 64'(imem_req_valid), 64'(0));
                    exp_q.delete();
                    exp_pc = redirect_pc & ~32'h3;
                end else if (instruction_valid) begin
                    if (first_val < 0) first_val = cyc;
                    if (decode_ready) begin
                        chk("word_expected", 64'(exp_q.size() != 0), 64'(1));
                        if (exp_q.size() != 0) begin
                            chk("deliver", {instruction_pc, instruction}, exp_q.pop_front());
                            n_deliv++;
                        end
                    end
                end else begin
                    chk("nop_when_idle", 64'(instruction), 64'h13);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic wait_valid(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clock);
            #1;
            ok = instruction_valid;
        end
        chk(tag, 64'(ok), 64'(1));
    endtask

    task automatic drain(input string tag);
        imem_req_ready = 1'b0;
        decode_ready   = 1'b1;
        for (int i = 0; i < 60 && (exp_q.size() != 0 || mem_q.size() != 0); i++) step(1);
        chk(tag, 64'(exp_q.size()), 64'(0));
        imem_req_ready = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'(0));
        chk({tag, "_req_addr"}, 64'(imem_req_addr), 64'(0));
        chk({tag, "_instr"}, 64'(instruction), 64'h13);
        chk({tag, "_instr_pc"}, 64'(instruction_pc), 64'(0));
        chk({tag, "_instr_valid"}, 64'(instruction_valid), 64'(0));
        chk({tag, "_misaligned"}, 64'(fetch_misaligned), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        imem_req_ready = 1'b1;
        decode_ready   = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        step(2);
        check_reset_outputs("rst");
        @(negedge clock);
        reset_n = 1'b1;

        // Latency 1, always ready: sequential addresses, two-cycle accept-to-valid.
        step(20);
        chk("t1_latency", 64'(first_val - first_acc), 64'(2));
        chk("t1_progress", 64'(n_deliv >= 5), 64'(1));
        repeat (30) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            decode_ready   = 1'($urandom_range(0, 1));
            step(1);
        end
        drain("t1_drain");

        // Decode stall: credits cap outstanding + buffered at two.
        decode_ready = 1'b1;
        step(5);
        decode_ready = 1'b0;
        step(10);
        chk("t2_req_valid_low", 64'(imem_req_valid), 64'(0));
        chk("t2_head_valid", 64'(instruction_valid), 64'(1));
        chk("t2_buffered", 64'(exp_q.size()), 64'(2));
        decode_ready = 1'b1;
        drain("t2_drain");

        // Latency 3, two in flight, redirect to 0x100.
        lat = 3;
        for (int i = 0; i < 20 && mem_q.size() != 2; i++) step(1);
        chk("t3_two_in_flight", 64'(mem_q.size()), 64'(2));
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step(1);
        redirect_valid = 1'b0;
        chk("t3_empty_after_redirect", 64'(instruction_valid), 64'(0));
        wait_valid("t3_wait_valid");
        chk("t3_first_pc", 64'(instruction_pc), 64'h100);
        drain("t3_drain");

        // Redirect together with a response and a pop.
        lat   = 1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1);
            found = imem_resp_valid && instruction_valid;
        end
        chk("t4_found_overlap", 64'(found), 64'(1));
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step(1);
        redirect_valid = 1'b0;
        chk("t4_fifo_empty", 64'(instruction_valid), 64'(0));
        wait_valid("t4_wait_valid");
        chk("t4_first_pc", 64'(instruction_pc), 64'h300);
        drain("t4_drain");

        // Asynchronous reset mid-stream, away from the clock edge.
        step(8);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        step(2);
        @(negedge clock);
        first_acc = -1;
        first_val = -1;
        reset_n   = 1'b1;
        wait_valid("t5_wait_valid");
        chk("t5_restart_pc", 64'(instruction_pc), 64'(0));
        chk("t5_latency", 64'(first_val - first_acc), 64'(2));
        drain("t5_drain");

        // Misaligned redirect.
        step(4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step(1);
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("t6_misaligned_set", 64'(fetch_misaligned), 64'(1));
        reqs = 0;
        repeat (10) begin
            step(1);
            if (imem_req_valid) reqs++;
        end
        chk("t6_halt_no_req", 64'(reqs), 64'(0));
        chk("t6_halt_empty", 64'(instruction_valid), 64'(0));
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step(1);
        redirect_valid = 1'b0;
        chk("t6_misaligned_clear", 64'(fetch_misaligned), 64'(0));
        wait_valid("t6_wait_valid");
        chk("t6_resume_pc", 64'(instruction_pc), 64'h200);
`else
        reqs = 0;
        chk("t6_misaligned_tied", 64'(fetch_misaligned), 64'(0));
        wait_valid("t6_wait_valid");
        chk("t6_aligned_pc", 64'(instruction_pc), 64'h100);
`endif
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
